moore_seq_detect_param: RTL and testbench

//   Parametrised Moore-type serial bit-pattern detector. Generalises the fixed 4-bit "1010"

---
 rtl/moore_seq_detect_param.sv | 165 ++++++++++++++++
 tb/tb_moore_seq_detect_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect_param.sv
// ---------------------------------------------------------------------------
// moore_seq_detect_param
//   Parametrised Moore serial bit-pattern detector with a saturating match
//   counter. The FSM state index k (0..PAT_LEN) is the number of pattern bits
//   matched so far. Index PAT_LEN is ACCEPT. The transition table is a KMP
//   fallback table that is built at elaboration from PATTERN, so nothing
//   about the pattern is stored at runtime.
//
// Parameters
//   PAT_LEN  pattern length, 2..16
//   PATTERN  pattern bits; PATTERN[PAT_LEN-1] is received first
//   OVERLAP  1: overlapping matches; 0: restart search after each match
//   CNT_W    match counter width, 1..32
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset (overrides en, clr_count)
//   en           in   1: sample 'in' this edge; 0: hold all state
//   in           in   serial data bit
//   clr_count    in   synchronous clear of match_count (beats increment)
//   out          out  high while FSM is in ACCEPT
//   match_count  out  saturating count of matches since reset/clear
//   state_dbg    out  current state index 0..PAT_LEN
// ---------------------------------------------------------------------------
module moore_seq_detect_param #(
  parameter int          PAT_LEN = 4,
  parameter logic [15:0] PATTERN = 16'b0000_0000_0000_1010,
  parameter bit          OVERLAP = 1'b1,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             clr_count,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [4:0]       state_dbg
);

  typedef enum logic [4:0] {
    S0  = 5'd0,  S1  = 5'd1,  S2  = 5'd2,  S3  = 5'd3,
    S4  = 5'd4,  S5  = 5'd5,  S6  = 5'd6,  S7  = 5'd7,
    S8  = 5'd8,  S9  = 5'd9,  S10 = 5'd10, S11 = 5'd11,
    S12 = 5'd12, S13 = 5'd13, S14 = 5'd14, S15 = 5'd15,
    S16 = 5'd16
  } state_e;

  localparam state_e           ACCEPT  = state_e'(PAT_LEN[4:0]);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Elaboration-time parameter legality checks.
  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("moore_seq_detect_param: PAT_LEN must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("moore_seq_detect_param: CNT_W must be in 1..32");
  end

  // KMP fallback: from state k on bit b, the new state is the longest prefix
  // of the pattern (length <= k+1, capped at PAT_LEN) that is a suffix of
  // "first k pattern bits followed by b". ext[0] is the oldest bit.
  function automatic logic [4:0] kmp_next(input int k, input logic b);
    logic [16:0] ext;
    int          len;
    logic [4:0]  best;
    logic        same;
    ext  = 17'd0;
    len  = k + 1;
    best = 5'd0;
    for (int i = 0; i < 17; i++) begin
      if (i < k) begin
        ext[i] = PATTERN[PAT_LEN-1-i];
      end else if (i == k) begin
        ext[i] = b;
      end else begin
        ext[i] = 1'b0;
      end
    end
    for (int j = 1; j <= 16; j++) begin
      if (j <= len && j <= PAT_LEN) begin
        same = 1'b1;
        for (int m = 0; m < j; m++) begin
          if (ext[len-j+m] != PATTERN[PAT_LEN-1-m]) begin
            same = 1'b0;
          end else begin
            same = same;
          end
        end
        if (same) begin
          best = j[4:0];
        end else begin
          best = best;
        end
      end else begin
        best = best;
      end
    end
    return best;
  endfunction

  // Constant next-state table; unused rows beyond PAT_LEN fall back to S0.
  logic [4:0] nxt_tbl_s [0:16][0:1];

  for (genvar gk = 0; gk <= 16; gk++) begin : g_tbl
    if (gk > PAT_LEN) begin : g_unused
      assign nxt_tbl_s[gk][0] = 5'd0;
      assign nxt_tbl_s[gk][1] = 5'd0;
    end else if (gk == PAT_LEN && !OVERLAP) begin : g_accept_restart
      // Non-overlapping: ACCEPT behaves as S0 for the next bit.
      localparam logic [4:0] NX0 = kmp_next(0, 1'b0);
      localparam logic [4:0] NX1 = kmp_next(0, 1'b1);
      assign nxt_tbl_s[gk][0] = NX0;
      assign nxt_tbl_s[gk][1] = NX1;
    end else begin : g_row
      localparam logic [4:0] NX0 = kmp_next(gk, 1'b0);
      localparam logic [4:0] NX1 = kmp_next(gk, 1'b1);
      assign nxt_tbl_s[gk][0] = NX0;
      assign nxt_tbl_s[gk][1] = NX1;
    end
  end

  state_e           state_q = S0;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next-state lookup and saturating counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      if (state_q <= ACCEPT) begin
        state_d = state_e'(nxt_tbl_s[state_q][in]);
      end else begin
        state_d = S0;
      end
    end else begin
      state_d = state_q;
    end
    if (clr_count) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en && state_d == ACCEPT && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out         = (state_q == ACCEPT);
  assign match_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_moore_seq_detect_param.sv
module tb_moore_seq_detect_param;

  localparam int NI = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic in_b = 1'b0;
  logic clr = 1'b0;

  logic        out_a [NI];
  logic [4:0]  st_a  [NI];
  logic [7:0]  c8_0, c8_1, c8_2, c8_3, c8_5;
  logic [1:0]  c2_4;
  logic [31:0] cnt_a [NI];

  assign cnt_a[0] = {24'd0, c8_0};
  assign cnt_a[1] = {24'd0, c8_1};
  assign cnt_a[2] = {24'd0, c8_2};
  assign cnt_a[3] = {24'd0, c8_3};
  assign cnt_a[4] = {30'd0, c2_4};
  assign cnt_a[5] = {24'd0, c8_5};

  // Instance configurations (mirrored in the model tables below).
  int p_len [NI] = '{4, 4, 4, 4, 4, 7};
  int p_pat [NI] = '{10, 10, 15, 15, 10, 109};
  int p_ov  [NI] = '{1, 0, 1, 0, 1, 1};
  int p_cw  [NI] = '{8, 8, 8, 8, 2, 8};

  moore_seq_detect_param #(.PAT_LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .clr_count(clr),
    .out(out_a[0]), .match_count(c8_0), .state_dbg(st_a[0]));
  moore_seq_detect_param #(.PAT_LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .clr_count(clr),
    .out(out_a[1]), .match_count(c8_1), .state_dbg(st_a[1]));
  moore_seq_detect_param #(.PAT_LEN(4), .PATTERN(16'b1111), .OVERLAP(1'b1), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .clr_count(clr),
    .out(out_a[2]), .match_count(c8_2), .state_dbg(st_a[2]));
  moore_seq_detect_param #(.PAT_LEN(4), .PATTERN(16'b1111), .OVERLAP(1'b0), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .clr_count(clr),
    .out(out_a[3]), .match_count(c8_3), .state_dbg(st_a[3]));
  moore_seq_detect_param #(.PAT_LEN(4), .PATTERN(16'b1010), .OVERLAP(1'b1), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .clr_count(clr),
    .out(out_a[4]), .match_count(c2_4), .state_dbg(st_a[4]));
  moore_seq_detect_param #(.PAT_LEN(7), .PATTERN(16'b1101101), .OVERLAP(1'b1), .CNT_W(8)) dut5 (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .clr_count(clr),
    .out(out_a[5]), .match_count(c8_5), .state_dbg(st_a[5]));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: recent history of sampled bits (newest in bit 0),
  // restarted on reset and, without overlap, after each match.
  int    m_hist [NI];
  int    m_hlen [NI];
  bit    m_acc  [NI];
  longint m_cnt [NI];

  function automatic int exp_st(int i);
    int l = p_len[i];
    int top = (m_hlen[i] < l) ? m_hlen[i] : l;
    if (m_acc[i]) return l;
    for (int j = top; j > 0; j--) begin
      if ((m_hist[i] & ((1 << j) - 1)) == (p_pat[i] >> (l - j))) return j;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic b, input logic c);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_hist[i] = 0; m_hlen[i] = 0; m_acc[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        if (e) begin
          if (!p_ov[i] && m_acc[i]) begin
            m_hist[i] = 0; m_hlen[i] = 0;
          end
          m_hist[i] = ((m_hist[i] << 1) | int'(b)) & ((1 << p_len[i]) - 1);
          if (m_hlen[i] < p_len[i]) m_hlen[i]++;
          m_acc[i] = (m_hlen[i] == p_len[i]) && (m_hist[i] == p_pat[i]);
        end
        if (c) m_cnt[i] = 0;
        else if (e && m_acc[i] && m_cnt[i] < ((64'd1 << p_cw[i]) - 1)) m_cnt[i]++;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic b, input logic c);
    @(negedge clk);
    rst = r; en = e; in_b = b; clr = c;
    @(posedge clk);
    model_edge(r, e, b, c);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (out_a[i] !== 1'b0 || st_a[i] !== 5'd0 || cnt_a[i] !== 32'd0) begin
        n_err++;
        $display("FAIL reset inst%0d got out=%0b st=%0d cnt=%0d want 0/0/0", i, out_a[i], st_a[i], cnt_a[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] s = 8'b10101010;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, s[7-k], 1'b0);
      for (int i = 0; i < NI; i++) begin
        n_vec++;
        if (out_a[i] !== m_acc[i] || st_a[i] !== 5'(exp_st(i)) || cnt_a[i] !== 32'(m_cnt[i])) begin
          n_err++;
          $display("FAIL basic inst%0d bit%0d got %0b/%0d/%0d want %0b/%0d/%0d", i, k + 1,
                   out_a[i], st_a[i], cnt_a[i], m_acc[i], exp_st(i), m_cnt[i]);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (out_a[0] !== 1'b1 || cnt_a[0] !== 32'd2 || cnt_a[1] !== 32'd1 || out_a[1] !== 1'b0) begin
          n_err++;
          $display("FAIL basic_6bits got ov out=%0b cnt=%0d nov out=%0b cnt=%0d want 1/2 0/1",
                   out_a[0], cnt_a[0], out_a[1], cnt_a[1]);
        end
      end
    end
    n_vec++;
    if (out_a[1] !== 1'b1 || cnt_a[1] !== 32'd2 || cnt_a[0] !== 32'd3) begin
      n_err++;
      $display("FAIL basic_8bits got nov out=%0b cnt=%0d ov cnt=%0d want 1/2 ov 3", out_a[1], cnt_a[1], cnt_a[0]);
    end
  endtask

  task automatic test_en_gaps();
    logic [6:0] b_v = 7'b1000010;
    logic [6:0] e_v = 7'b1100011;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, e_v[6-k], (k < 2) ? b_v[6-k] : ((k == 5) ? 1'b1 : 1'b0), 1'b0);
      for (int i = 0; i < NI; i++) begin
        n_vec++;
        if (out_a[i] !== m_acc[i] || st_a[i] !== 5'(exp_st(i)) || cnt_a[i] !== 32'(m_cnt[i])) begin
          n_err++;
          $display("FAIL en_gap inst%0d step%0d got %0b/%0d/%0d want %0b/%0d/%0d", i, k,
                   out_a[i], st_a[i], cnt_a[i], m_acc[i], exp_st(i), m_cnt[i]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, k[0], 1'b0);
      n_vec++;
      if (out_a[0] !== 1'b1 || cnt_a[0] !== 32'd1) begin
        n_err++;
        $display("FAIL en_hold got out=%0b cnt=%0d want 1/1", out_a[0], cnt_a[0]);
      end
    end
  endtask

  task automatic test_self_overlap();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      n_vec++;
      if (out_a[2] !== (k >= 4) || cnt_a[2] !== 32'((k >= 4) ? k - 3 : 0)) begin
        n_err++;
        $display("FAIL ones_ov bit%0d got out=%0b cnt=%0d want %0b/%0d", k, out_a[2], cnt_a[2],
                 (k >= 4), (k >= 4) ? k - 3 : 0);
      end
      n_vec++;
      if (out_a[3] !== (k == 4) || st_a[3] !== 5'(exp_st(3)) || cnt_a[3] !== 32'((k >= 4) ? 1 : 0)) begin
        n_err++;
        $display("FAIL ones_nov bit%0d got out=%0b st=%0d cnt=%0d want %0b/%0d/%0d", k, out_a[3], st_a[3],
                 cnt_a[3], (k == 4), exp_st(3), (k >= 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_c [5] = '{1, 2, 3, 3, 3};
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 5; m++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (out_a[4] !== 1'b1 || cnt_a[4] !== 32'(exp_c[m])) begin
        n_err++;
        $display("FAIL sat match%0d got out=%0b cnt=%0d want 1/%0d", m + 1, out_a[4], cnt_a[4], exp_c[m]);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (out_a[4] !== 1'b1 || cnt_a[4] !== 32'd0 || cnt_a[0] !== 32'd0) begin
      n_err++;
      $display("FAIL clr_on_match got out=%0b cnt=%0d cnt0=%0d want 1/0/0", out_a[4], cnt_a[4], cnt_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s = 4'b1010;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (st_a[0] !== 5'd0 || out_a[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid got st=%0d out=%0b want 0/0", st_a[0], out_a[0]);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (st_a[0] !== 5'd0 || out_a[0] !== 1'b0 || cnt_a[0] !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_zero got st=%0d out=%0b cnt=%0d want 0/0/0", st_a[0], out_a[0], cnt_a[0]);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, s[3-k], 1'b0);
    n_vec++;
    if (out_a[0] !== 1'b1 || cnt_a[0] !== 32'd1 || st_a[0] !== 5'd4) begin
      n_err++;
      $display("FAIL rst_mid_match got out=%0b cnt=%0d st=%0d want 1/1/4", out_a[0], cnt_a[0], st_a[0]);
    end
  endtask

  task automatic test_random();
    logic r, e, b, c;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      b = $urandom_range(0, 1) != 0;
      c = ($urandom_range(0, 39) == 0);
      step(r, e, b, c);
      for (int i = 0; i < NI; i++) begin
        n_vec++;
        if (out_a[i] !== m_acc[i] || st_a[i] !== 5'(exp_st(i)) || cnt_a[i] !== 32'(m_cnt[i])) begin
          n_err++;
          $display("FAIL random inst%0d cyc%0d got %0b/%0d/%0d want %0b/%0d/%0d", i, k,
                   out_a[i], st_a[i], cnt_a[i], m_acc[i], exp_st(i), m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_hist[i] = 0; m_hlen[i] = 0; m_acc[i] = 1'b0; m_cnt[i] = 0;
    end
    test_reset();
    test_basic();
    test_en_gaps();
    test_self_overlap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
